// File: rtl/alu_pkg.sv
// Shared ALU op encodings and arbiter FSM state encoding.
package alu_pkg;

    typedef enum logic [2:0] {
        AluAnd  = 3'b000,
        AluOr   = 3'b001,
        AluAdd  = 3'b010,
        AluLui  = 3'b011,
        AluSltu = 3'b100,
        AluSub  = 3'b110,
        AluSlt  = 3'b111
    } aluop_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU: result plus flags {err, overflow, carry, zero}.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [2:0]            op,
    output logic [DATA_WIDTH-1:0] result,
    output logic [3:0]            flags
);

    localparam int unsigned Msb = DATA_WIDTH - 1;

    logic [DATA_WIDTH:0] sum;
    logic [DATA_WIDTH:0] diff;
    logic                ovf;
    logic                carry;
    logic                err;
    logic                lt_s;
    logic                lt_u;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        // Subtraction as a + ~b + 1, so carry set means no borrow.
        diff   = {1'b0, a} + {1'b0, ~b} + {{DATA_WIDTH{1'b0}}, 1'b1};
        lt_s   = $signed(a) < $signed(b);
        lt_u   = a < b;
        result = '0;
        ovf    = 1'b0;
        carry  = 1'b0;
        err    = 1'b0;
        case (op)
            AluAnd:  result = a & b;
            AluOr:   result = a | b;
            AluAdd: begin
                result = sum[Msb:0];
                carry  = sum[DATA_WIDTH];
                ovf    = (a[Msb] == b[Msb]) && (sum[Msb] != a[Msb]);
            end
            AluSub: begin
                result = diff[Msb:0];
                carry  = diff[DATA_WIDTH];
                ovf    = (a[Msb] != b[Msb]) && (diff[Msb] != a[Msb]);
            end
            AluSlt:  result = {{(DATA_WIDTH-1){1'b0}}, lt_s};
            AluSltu: result = {{(DATA_WIDTH-1){1'b0}}, lt_u};
            AluLui:  result = b << 16;
            default: err = 1'b1;
        endcase
        flags = {err, ovf, carry, (result == '0) && !err};
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one ALU; one op in flight at a time.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic [2:0]            req0_op,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    input  logic [2:0]            req1_op,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic [3:0]            rsp_flags,
    output logic                  busy
);

    state_e                state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic                  id_q;
    logic                  grant;
    logic                  grant_id;
    logic [DATA_WIDTH-1:0] a_q, b_q, result_q, alu_result;
    logic [2:0]            op_q;
    logic [3:0]            flags_q, alu_flags;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant      = 1'b0;
        grant_id   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (req0_valid || req1_valid) begin
                    grant    = 1'b1;
                    // Pointer only matters on contention; a lone requester always wins.
                    grant_id = (req0_valid && req1_valid) ? ptr_q : req1_valid;
                    ptr_d    = ~grant_id;
                    state_d  = StExec;
                end
            end
            StExec: state_d = StResp;
            StResp: begin
                if ((!id_q && rsp0_ready) || (id_q && rsp1_ready)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        req0_ready = grant && !grant_id && !rst;
        req1_ready = grant && grant_id && !rst;
        rsp0_valid = (state_q == StResp) && !id_q && !rst;
        rsp1_valid = (state_q == StResp) && id_q && !rst;
        busy       = (state_q != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            ptr_q    <= 1'b0;
            id_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (grant) begin
                id_q <= grant_id;
                a_q  <= grant_id ? req1_a : req0_a;
                b_q  <= grant_id ? req1_b : req0_b;
                op_q <= grant_id ? req1_op : req0_op;
            end
            if (state_q == StExec) begin
                result_q <= alu_result;
                flags_q  <= alu_flags;
            end
        end
    end

    alu #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu (
        .a     (a_q),
        .b     (b_q),
        .op    (op_q),
        .result(alu_result),
        .flags (alu_flags)
    );

    assign rsp_result = result_q;
    assign rsp_flags  = flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, reset corners, random ops vs model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        busy;

    int total = 0;
    int bad   = 0;
    bit mptr  = 1'b0;

    always #5 clk = ~clk;

    alu_arbiter #(
        .DATA_WIDTH(32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req0_op   (req0_op),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req1_op   (req1_op),
        .rsp0_valid(rsp0_valid),
        .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid),
        .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result),
        .rsp_flags (rsp_flags),
        .busy      (busy)
    );

    typedef struct {
        bit          who;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        int          hold;
        logic [31:0] r;
        logic [3:0]  f;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: true arithmetic in 64 bits, flags derived from the mathematical result.
    function automatic logic [35:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        longint          sa, sb, s;
        longint unsigned ua, ub;
        logic [31:0]     r;
        logic            v, c, e;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = a;
        ub = b;
        s  = 0;
        r  = 0;
        v  = 0;
        c  = 0;
        e  = 0;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: begin
                s = sa + sb;
                r = 32'(ua + ub);
                c = (ua + ub) > 64'hFFFF_FFFF;
                v = s != longint'($signed(r));
            end
            3'b110: begin
                s = sa - sb;
                r = 32'(ua - ub);
                c = ua >= ub;
                v = s != longint'($signed(r));
            end
            3'b111: r = (sa < sb) ? 32'd1 : 32'd0;
            3'b100: r = (ua < ub) ? 32'd1 : 32'd0;
            3'b011: r = {b[15:0], 16'h0000};
            default: e = 1;
        endcase
        return {e, v, c, (!e && r == 0), r};
    endfunction

    task automatic scramble();
        req0_valid = 1'($urandom);
        req1_valid = 1'($urandom);
        req0_a = $urandom; req0_b = $urandom; req0_op = 3'($urandom);
        req1_a = $urandom; req1_b = $urandom; req1_op = 3'($urandom);
    endtask

    // Entered at a negedge with the DUT idle; leaves at a negedge with the DUT idle.
    task automatic txn(input bit v0, input bit v1, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [2:0] op0, input logic [31:0] a1, input logic [31:0] b1,
                       input logic [2:0] op1, input int hold, input bit use_model,
                       input logic [31:0] er, input logic [3:0] ef, input string nm);
        int          w;
        logic [35:0] m;
        logic [31:0] exp_r;
        logic [3:0]  exp_f;
        w     = (v0 && v1) ? int'(mptr) : (v1 ? 1 : 0);
        mptr  = (w == 0);
        exp_r = er;
        exp_f = ef;
        if (use_model) begin
            m     = (w == 0) ? ref_alu(a0, b0, op0) : ref_alu(a1, b1, op1);
            exp_r = m[31:0];
            exp_f = m[35:32];
        end
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
        rsp0_ready = (hold == 0);
        rsp1_ready = (hold == 0);
        #1;
        chk({nm, " grant0"}, req0_ready, w == 0);
        chk({nm, " grant1"}, req1_ready, w == 1);
        @(posedge clk); @(negedge clk);
        scramble();
        #1;
        chk({nm, " exec busy"}, busy, 1);
        chk({nm, " exec ready"}, {req0_ready, req1_ready}, 0);
        chk({nm, " exec rspvalid"}, {rsp0_valid, rsp1_valid}, 0);
        @(posedge clk); @(negedge clk);
        scramble();
        #1;
        chk({nm, " rsp valid"}, {rsp1_valid, rsp0_valid}, (w == 1) ? 2'b10 : 2'b01);
        chk({nm, " result"}, rsp_result, exp_r);
        chk({nm, " flags"}, rsp_flags, exp_f);
        chk({nm, " resp ready"}, {req0_ready, req1_ready}, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            scramble();
            #1;
            chk({nm, " hold result"}, rsp_result, exp_r);
            chk({nm, " hold flags"}, rsp_flags, exp_f);
            chk({nm, " hold busy"}, busy, 1);
            chk({nm, " hold valid"}, {rsp1_valid, rsp0_valid}, (w == 1) ? 2'b10 : 2'b01);
            chk({nm, " hold ready"}, {req0_ready, req1_ready}, 0);
        end
        rsp0_ready = 1;
        rsp1_ready = 1;
        @(posedge clk); @(negedge clk);
        req0_valid = 0;
        req1_valid = 0;
        rsp0_ready = 0;
        rsp1_ready = 0;
        #1;
        chk({nm, " idle busy"}, busy, 0);
        chk({nm, " idle rspvalid"}, {rsp0_valid, rsp1_valid}, 0);
    endtask

    initial begin
        vecs[0]  = '{0, 32'h7FFF_FFFF, 32'h0000_0001, 3'b010, 5, 32'h8000_0000, 4'b0100};
        vecs[1]  = '{1, 32'h0000_0005, 32'h0000_0005, 3'b110, 0, 32'h0000_0000, 4'b0011};
        vecs[2]  = '{1, 32'hFFFF_FFFF, 32'h0000_0001, 3'b111, 0, 32'h0000_0001, 4'b0000};
        vecs[3]  = '{0, 32'h1234_5678, 32'h9ABC_DEF0, 3'b101, 0, 32'h0000_0000, 4'b1000};
        vecs[4]  = '{0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b000, 0, 32'h00F0_00F0, 4'b0000};
        vecs[5]  = '{1, 32'h0000_0000, 32'h0000_0000, 3'b001, 2, 32'h0000_0000, 4'b0001};
        vecs[6]  = '{0, 32'hDEAD_BEEF, 32'h0000_1234, 3'b011, 0, 32'h1234_0000, 4'b0000};
        vecs[7]  = '{1, 32'h0000_0001, 32'hFFFF_FFFF, 3'b100, 0, 32'h0000_0001, 4'b0000};
        vecs[8]  = '{0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b010, 0, 32'h0000_0000, 4'b0011};
        vecs[9]  = '{1, 32'h0000_0000, 32'h0000_0001, 3'b110, 0, 32'hFFFF_FFFF, 4'b0000};
        vecs[10] = '{0, 32'h8000_0000, 32'h0000_0001, 3'b110, 1, 32'h7FFF_FFFF, 4'b0110};

        rst = 1;
        req0_valid = 1; req1_valid = 0;
        req0_a = 0; req0_b = 0; req0_op = 0;
        req1_a = 0; req1_b = 0; req1_op = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ready", {req0_ready, req1_ready}, 0);
        chk("reset rspvalid", {rsp0_valid, rsp1_valid}, 0);
        chk("reset result", rsp_result, 0);
        chk("reset flags", rsp_flags, 0);
        chk("reset busy", busy, 0);
        rst = 0;
        req0_valid = 0;
        mptr = 0;

        // Contention after reset: req0 first, then strict alternation.
        for (int i = 0; i < 4; i++)
            txn(1, 1, $urandom, $urandom, 3'b010, $urandom, $urandom, 3'b010, 0, 1, 0, 0,
                "arb");

        for (int i = 0; i < 11; i++)
            txn(!vecs[i].who, vecs[i].who, vecs[i].a, vecs[i].b, vecs[i].op,
                vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].hold, 0, vecs[i].r, vecs[i].f,
                $sformatf("vec%0d", i));

        // req0 stalled with req1 pending, then req1 served straight from idle.
        txn(1, 0, 32'd3, 32'd4, 3'b010, 0, 0, 0, 5, 0, 32'd7, 4'b0000, "stall0");
        txn(0, 1, 0, 0, 0, 32'd9, 32'd2, 3'b110, 0, 0, 32'd7, 4'b0010, "after_stall");

        // Reset during RESP: response abandoned, pointer back at requester 0.
        mptr = 0;
        txn(1, 1, 32'd1, 32'd1, 3'b010, 32'd2, 32'd2, 3'b010, 0, 1, 0, 0, "pre_rst");
        req0_valid = 1; req1_valid = 1;
        req0_a = 32'd10; req0_b = 32'd20; req0_op = 3'b010;
        #1;
        chk("rstseq grant1", req1_ready, 1);
        @(posedge clk); @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        @(posedge clk); @(negedge clk);
        chk("rstseq rsp1 valid", rsp1_valid, 1);
        rst = 1;
        #1;
        chk("rst override valid", rsp1_valid, 0);
        @(posedge clk); @(negedge clk);
        rst = 0;
        rsp1_ready = 1;
        #1;
        chk("post rst busy", busy, 0);
        chk("post rst result", rsp_result, 0);
        chk("post rst flags", rsp_flags, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            chk("no stale rsp", {rsp0_valid, rsp1_valid, busy}, 0);
        end
        rsp1_ready = 0;
        mptr = 0;
        txn(1, 1, 32'd6, 32'd3, 3'b001, 32'd1, 32'd1, 3'b000, 0, 1, 0, 0, "ptr_reset");

        for (int i = 0; i < 40; i++) begin
            int pat;
            pat = $urandom_range(1, 3);
            txn(pat[0], pat[1], $urandom, (i % 5 == 0) ? 32'd0 : $urandom, 3'($urandom),
                $urandom, $urandom, 3'($urandom), $urandom_range(0, 3), 1, 0, 0,
                $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
